// File: rtl/lot_ticket_entry_pkg.sv
// Shared constants, state encoding and digit check for the lottery ticket entry stage.
package lot_pkg;

    localparam int unsigned NUM_DIGITS = 5;
    localparam int unsigned MAX_DIGIT  = 9;
    localparam int unsigned TICKET_W   = 4 * NUM_DIGITS;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    // Digit code kept in an empty display slot; the decoder blanks it.
    localparam logic [3:0] DIGIT_NONE = 4'hF;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        COLLECT  = 4'd1,
        WAIT_FIM = 4'd2,
        PRESENT  = 4'd3,
        ERR      = 4'd4
    } lot_state_t;

    function automatic logic digit_ok(input logic [3:0] d);
        return d <= 4'(MAX_DIGIT);
    endfunction

endpackage

// File: rtl/lot_seg7_dec.sv
// Combinational BCD to active-low seven-segment decoder; seg[0] is segment a, seg[6] is g.
module lot_seg7_dec
    import lot_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [0:6] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/lot_ticket_entry.sv
// Lottery ticket entry stage: collects BCD digits, validates them and presents the ticket
// over valid/ready. Optional seven-segment echo outputs under LOT_TICKET_HEX_EN.
module lot_ticket_entry
    import lot_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [0:3]          num,
    input  logic                insere,
    input  logic                fim,
    input  logic                fim_jogo,
    input  logic                ticket_ready,
    output logic [0:TICKET_W-1] ticket,
    output logic                ticket_valid,
    output logic                err,
    output logic [0:2]          dcount,
    output logic [0:3]          state
`ifdef LOT_TICKET_HEX_EN
    ,
    output logic [0:6]          hex3,
    output logic [0:6]          hex2,
    output logic [0:6]          hex1,
    output logic [0:6]          hex0
`endif
);

    lot_state_t st;
    logic [2:0] cnt;
    logic [3:0] digit;
    logic       dig_ok;

    assign digit  = num;
    assign dig_ok = digit_ok(digit);
    assign dcount = cnt;
    assign state  = st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st           <= IDLE;
            ticket       <= '0;
            cnt          <= '0;
            ticket_valid <= 1'b0;
            err          <= 1'b0;
        end else if (fim_jogo) begin
            st           <= IDLE;
            cnt          <= '0;
            ticket_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (insere) begin
                        if (dig_ok) begin
                            ticket <= {digit, {(TICKET_W-4){1'b0}}};
                            cnt    <= 3'd1;
                            st     <= COLLECT;
                        end else begin
                            err <= 1'b1;
                            st  <= ERR;
                        end
                    end
                end
                COLLECT: begin
                    if (insere) begin
                        if (!dig_ok) begin
                            err <= 1'b1;
                            st  <= ERR;
                        end else begin
                            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                                if (cnt == 3'(k)) ticket[4*k +: 4] <= digit;
                            end
                            cnt <= cnt + 3'd1;
                            // A digit arriving together with fim is stored before fim is judged.
                            if (cnt + 3'd1 == 3'(NUM_DIGITS)) begin
                                if (fim) begin
                                    ticket_valid <= 1'b1;
                                    st           <= PRESENT;
                                end else begin
                                    st <= WAIT_FIM;
                                end
                            end else if (fim) begin
                                err <= 1'b1;
                                st  <= ERR;
                            end
                        end
                    end else if (fim) begin
                        err <= 1'b1;
                        st  <= ERR;
                    end
                end
                WAIT_FIM: begin
                    if (insere) begin
                        err <= 1'b1;
                        st  <= ERR;
                    end else if (fim) begin
                        ticket_valid <= 1'b1;
                        st           <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ticket_ready) begin
                        ticket_valid <= 1'b0;
                        cnt          <= '0;
                        st           <= IDLE;
                    end
                end
                ERR: begin
                    err <= 1'b1;
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

`ifdef LOT_TICKET_HEX_EN
    logic [3:0] hexd [4];
    logic       new_ticket;
    logic       take_digit;

    assign new_ticket = insere && dig_ok && (st == IDLE);
    assign take_digit = insere && dig_ok && (st == COLLECT);

    // hexd[0] holds the most recent digit; older digits shift towards hexd[3].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) hexd[i] <= DIGIT_NONE;
        end else if (fim_jogo) begin
            for (int unsigned i = 0; i < 4; i++) hexd[i] <= DIGIT_NONE;
        end else if (new_ticket) begin
            hexd[0] <= digit;
            for (int unsigned i = 1; i < 4; i++) hexd[i] <= DIGIT_NONE;
        end else if (take_digit) begin
            hexd[0] <= digit;
            for (int unsigned i = 1; i < 4; i++) hexd[i] <= hexd[i-1];
        end
    end

    lot_seg7_dec u_hex0 (.bcd(hexd[0]), .seg(hex0));
    lot_seg7_dec u_hex1 (.bcd(hexd[1]), .seg(hex1));
    lot_seg7_dec u_hex2 (.bcd(hexd[2]), .seg(hex2));
    lot_seg7_dec u_hex3 (.bcd(hexd[3]), .seg(hex3));
`endif

endmodule

// File: tb/tb_lot_ticket_entry.sv
// Directed self-checking bench for lot_ticket_entry with a queue scoreboard for presented tickets.
module tb_lot_ticket_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:3]  num;
    logic        insere;
    logic        fim;
    logic        fim_jogo;
    logic        ticket_ready;
    logic [0:19] ticket;
    logic        ticket_valid;
    logic        err;
    logic [0:2]  dcount;
    logic [0:3]  state;

    int vectors     = 0;
    int miscompares = 0;
    logic [19:0] exp_q [$];

    lot_ticket_entry dut (
        .clk          (clk),
        .reset        (reset),
        .num          (num),
        .insere       (insere),
        .fim          (fim),
        .fim_jogo     (fim_jogo),
        .ticket_ready (ticket_ready),
        .ticket       (ticket),
        .ticket_valid (ticket_valid),
        .err          (err),
        .dcount       (dcount),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic digit(input logic [3:0] d);
        num    = d;
        insere = 1'b1;
        tick();
        insere = 1'b0;
    endtask

    task automatic pulse_fim_jogo();
        fim_jogo = 1'b1;
        tick();
        fim_jogo = 1'b0;
    endtask

    // Waits (bounded) for the DUT to present a ticket and compares it with the queue head.
    task automatic collect(input string tag);
        logic [19:0] e;
        for (int i = 0; i < 20 && !ticket_valid; i++) tick();
        check({tag, "_valid"}, 32'(ticket_valid), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_ticket"}, 32'(ticket), 32'(e));
        end else begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end
    endtask

    initial begin
        reset        = 1'b0;
        num          = 4'd0;
        insere       = 1'b0;
        fim          = 1'b0;
        fim_jogo     = 1'b0;
        ticket_ready = 1'b0;

        #2;
        check("rst_ticket", 32'(ticket), 32'h0);
        check("rst_valid",  32'(ticket_valid), 32'd0);
        check("rst_err",    32'(err), 32'd0);
        check("rst_dcount", 32'(dcount), 32'd0);
        check("rst_state",  32'(state), 32'd0);
        #10 reset = 1'b1;
        tick();

        // fim alone in IDLE is ignored
        fim = 1'b1;
        tick();
        fim = 1'b0;
        check("idle_fim_state", 32'(state), 32'd0);
        check("idle_fim_err",   32'(err), 32'd0);

        // Test 1: full ticket, one-clock valid latency
        digit(4'd4); digit(4'd7); digit(4'd0); digit(4'd1); digit(4'd0);
        check("t1_dcount", 32'(dcount), 32'd5);
        check("t1_state",  32'(state), 32'd2);
        check("t1_valid_early", 32'(ticket_valid), 32'd0);
        exp_q.push_back(20'h47010);
        fim = 1'b1;
        tick();
        fim = 1'b0;
        check("t1_latency", 32'(ticket_valid), 32'd1);
        collect("t1");
        check("t1_dcount_p", 32'(dcount), 32'd5);

        // Test 2: backpressure holds the ticket stable
        for (int i = 0; i < 3; i++) begin
            insere = 1'b1;
            num    = 4'd3;
            fim    = 1'b1;
            tick();
            check("t2_hold_valid",  32'(ticket_valid), 32'd1);
            check("t2_hold_ticket", 32'(ticket), 32'h47010);
        end
        insere       = 1'b0;
        fim          = 1'b0;
        ticket_ready = 1'b1;
        tick();
        ticket_ready = 1'b0;
        check("t2_state",  32'(state), 32'd0);
        check("t2_valid",  32'(ticket_valid), 32'd0);
        check("t2_dcount", 32'(dcount), 32'd0);
        check("t2_ticket_kept", 32'(ticket), 32'h47010);

        // Test 3: gaps between digits
        digit(4'd6); digit(4'd7);
        tick(); tick();
        check("t3_gap_dcount", 32'(dcount), 32'd2);
        check("t3_gap_state",  32'(state), 32'd1);
        check("t3_new_ticket", 32'(ticket), 32'h67000);
        digit(4'd0); digit(4'd3); digit(4'd9);
        exp_q.push_back(20'h67039);
        fim = 1'b1;
        tick();
        fim = 1'b0;
        collect("t3");
        check("t3_err", 32'(err), 32'd0);
        ticket_ready = 1'b1;
        tick();
        ticket_ready = 1'b0;

        // Test 4: short ticket, then abort
        digit(4'd4); digit(4'd7); digit(4'd0);
        fim = 1'b1;
        tick();
        fim = 1'b0;
        check("t4_err",   32'(err), 32'd1);
        check("t4_state", 32'(state), 32'd4);
        digit(4'd5);
        check("t4_err_ignore", 32'(dcount), 32'd3);
        pulse_fim_jogo();
        check("t4_abort_err",    32'(err), 32'd0);
        check("t4_abort_state",  32'(state), 32'd0);
        check("t4_abort_dcount", 32'(dcount), 32'd0);
        check("t4_abort_ticket", 32'(ticket), 32'h47000);

        // Test 5: invalid digit is not stored
        digit(4'd2);
        digit(4'hC);
        check("t5_err",    32'(err), 32'd1);
        check("t5_dcount", 32'(dcount), 32'd1);
        check("t5_ticket", 32'(ticket), 32'h20000);
        pulse_fim_jogo();

        // Fifth digit together with fim goes straight to PRESENT
        digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
        exp_q.push_back(20'h12345);
        num    = 4'd5;
        insere = 1'b1;
        fim    = 1'b1;
        tick();
        insere = 1'b0;
        fim    = 1'b0;
        check("sim_state", 32'(state), 32'd3);
        collect("sim");
        ticket_ready = 1'b1;
        tick();
        ticket_ready = 1'b0;

        // Overlong ticket
        digit(4'd9); digit(4'd8); digit(4'd7); digit(4'd6); digit(4'd5);
        digit(4'd1);
        check("long_state",  32'(state), 32'd4);
        check("long_err",    32'(err), 32'd1);
        check("long_dcount", 32'(dcount), 32'd5);
        pulse_fim_jogo();

        // Invalid first digit
        digit(4'hA);
        check("first_bad_state", 32'(state), 32'd4);
        pulse_fim_jogo();

        // Test 6: asynchronous reset mid-collect
        digit(4'd1); digit(4'd2); digit(4'd3);
        check("t6_dcount", 32'(dcount), 32'd3);
        #3 reset = 1'b0;
        #1;
        check("t6_ticket", 32'(ticket), 32'h0);
        check("t6_dcount0", 32'(dcount), 32'd0);
        check("t6_state",  32'(state), 32'd0);
        check("t6_valid",  32'(ticket_valid), 32'd0);
        check("t6_err",    32'(err), 32'd0);
        #1 reset = 1'b1;
        tick();
        check("t6_after_state", 32'(state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
